// File: rtl/rim_pkg.sv
// Shared constants, FSM states and error codes for the rat-in-maze driver/checker.
package rim_pkg;
    localparam int N        = 8;
    localparam int PATH_LEN = 2 * N - 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND   = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_GUARD  = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_BAD_START = 3'd1;
    localparam logic [2:0] ERR_BAD_STEP  = 3'd2;
    localparam logic [2:0] ERR_BLOCKED   = 3'd3;
    localparam logic [2:0] ERR_SHORT     = 3'd4;
    localparam logic [2:0] ERR_LONG      = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd6;
    localparam logic [2:0] ERR_EARLY     = 3'd7;
endpackage

// File: rtl/rim_step_checker.sv
// Combinational legality check of one path beat against the previous beat and the maze.
module rim_step_checker
    import rim_pkg::*;
(
    input  logic             first,
    input  logic [2:0]       prev_row,
    input  logic [2:0]       prev_col,
    input  logic [2:0]       row,
    input  logic [2:0]       col,
    input  logic [N*N-1:0]   store_flat,
    output logic             ok,
    output logic [2:0]       err
);
    logic [3:0] down_row;
    logic [3:0] left_col;
    logic       adj;
    logic       open_cell;

    always_comb begin
        // 4-bit arithmetic so row 7+1 and col 0-1 can never alias a real cell
        down_row = {1'b0, prev_row} + 4'd1;
        left_col = {1'b0, prev_col} - 4'd1;
        if (first)
            adj = (row == 3'd0) && (col == 3'(N - 1));
        else
            adj = (({1'b0, row} == down_row) && (col == prev_col)) ||
                  ((row == prev_row) && ({1'b0, col} == left_col));
        open_cell = store_flat[{row, col}];
        ok  = 1'b1;
        err = ERR_OK;
        if (!adj) begin
            ok  = 1'b0;
            err = first ? ERR_BAD_START : ERR_BAD_STEP;
        end else if (!open_cell) begin
            ok  = 1'b0;
            err = ERR_BLOCKED;
        end
    end
endmodule

// File: rtl/rim_maze_driver.sv
// Sends an 8x8 maze to the solver as row beats, then checks the returned path beat by beat.
module rim_maze_driver
    import rim_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic [7:0] maze,
    output logic       in_valid,
    input  logic       out_valid,
    input  logic [2:0] out_row,
    input  logic [2:0] out_col,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_code,
    output logic [3:0] step_cnt,
    output logic [2:0] dbg_state
);
    localparam int WAIT_W = $clog2(TIMEOUT);

    state_t              state;
    logic [7:0]          store [N];
    logic [N*N-1:0]      store_flat;
    logic [3:0]          send_idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [2:0]          prev_row;
    logic [2:0]          prev_col;
    logic                beat_ok;
    logic [2:0]          beat_err;
    logic [7:0]          row0_fwd;

    always_comb begin
        store_flat = '0;
        for (int r = 0; r < N; r++)
            store_flat[r*N +: N] = store[r];
    end

    // A write in the start cycle must already be visible in the first row beat
    assign row0_fwd  = (cfg_we && cfg_addr == 3'd0) ? cfg_data : store[0];
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    rim_step_checker u_step (
        .first      (state == S_WAIT),
        .prev_row   (prev_row),
        .prev_col   (prev_col),
        .row        (out_row),
        .col        (out_col),
        .store_flat (store_flat),
        .ok         (beat_ok),
        .err        (beat_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            for (int r = 0; r < N; r++) store[r] <= 8'h00;
            maze     <= 8'h00;
            in_valid <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= ERR_OK;
            step_cnt <= 4'd0;
            send_idx <= 4'd0;
            wait_cnt <= '0;
            prev_row <= 3'd0;
            prev_col <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_we) store[cfg_addr] <= cfg_data;
                    if (start) begin
                        state    <= S_SEND;
                        pass     <= 1'b0;
                        err_code <= ERR_OK;
                        step_cnt <= 4'd0;
                        in_valid <= 1'b1;
                        maze     <= row0_fwd;
                        send_idx <= 4'd1;
                        wait_cnt <= '0;
                    end
                end
                S_SEND: begin
                    if (out_valid) begin
                        in_valid <= 1'b0;
                        maze     <= 8'h00;
                        err_code <= ERR_EARLY;
                        done     <= 1'b1;
                        state    <= S_REPORT;
                    end else if (send_idx == 4'(N)) begin
                        in_valid <= 1'b0;
                        maze     <= 8'h00;
                        state    <= S_WAIT;
                    end else begin
                        maze     <= store[send_idx[2:0]];
                        send_idx <= send_idx + 4'd1;
                    end
                end
                S_WAIT, S_CHECK: begin
                    if (out_valid) begin
                        if (!beat_ok) begin
                            err_code <= beat_err;
                            done     <= 1'b1;
                            state    <= S_REPORT;
                        end else begin
                            step_cnt <= (step_cnt == 4'hF) ? step_cnt : step_cnt + 4'd1;
                            prev_row <= out_row;
                            prev_col <= out_col;
                            state    <= (step_cnt == 4'(PATH_LEN - 1)) ? S_GUARD : S_CHECK;
                        end
                    end else if (state == S_CHECK) begin
                        err_code <= ERR_SHORT;
                        done     <= 1'b1;
                        state    <= S_REPORT;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        err_code <= ERR_TIMEOUT;
                        done     <= 1'b1;
                        state    <= S_REPORT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_GUARD: begin
                    // Any beat after a complete path means the solver overran
                    err_code <= out_valid ? ERR_LONG : ERR_OK;
                    pass     <= !out_valid;
                    done     <= 1'b1;
                    state    <= S_REPORT;
                end
                S_REPORT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rim_maze_driver.sv
// Randomized bench for rim_maze_driver: path-rule reference model plus decoupled result monitor.
module tb_rim_maze_driver;
    localparam int TIMEOUT  = 64;
    localparam int PATH_LEN = 15;
    localparam int M_PATH   = 0;
    localparam int M_EARLY  = 1;
    localparam int M_RESET  = 2;

    logic       clk = 1'b0;
    logic       rst, start, cfg_we, out_valid;
    logic [2:0] cfg_addr, out_row, out_col, err_code, dbg_state;
    logic [7:0] cfg_data, maze;
    logic       in_valid, busy, done, pass;
    logic [3:0] step_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         exp_lat_q[$];
    logic [7:0] exp_maze_q[$];
    logic [7:0] model_store[8];
    logic [7:0] load_rows[8];
    int         br[$];
    int         bc[$];
    int         cyc = 0;
    int         fall_cyc = 0;
    int         done_cnt = 0;
    logic       iv_prev = 1'b0;
    logic [7:0] mon_e;
    int         mon_l;

    rim_maze_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .maze(maze), .in_valid(in_valid), .out_valid(out_valid),
        .out_row(out_row), .out_col(out_col), .busy(busy), .done(done), .pass(pass),
        .err_code(err_code), .step_cnt(step_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk the beat list with the path rules; result packed as {pass, err, steps}
    function automatic logic [7:0] model_path();
        int pr = 0, pc = 0, cnt = 0;
        for (int i = 0; i < br.size(); i++) begin
            if (i == PATH_LEN) return {1'b0, 3'd5, 4'd15};
            if (i == 0) begin
                if (!(br[0] == 0 && bc[0] == 7)) return {1'b0, 3'd1, 4'd0};
            end else if (!((br[i] == pr + 1 && bc[i] == pc) || (br[i] == pr && bc[i] == pc - 1))) begin
                return {1'b0, 3'd2, 4'(cnt)};
            end
            if (model_store[br[i]][bc[i]] == 1'b0) return {1'b0, 3'd3, 4'(cnt)};
            cnt++;
            pr = br[i];
            pc = bc[i];
        end
        if (cnt == 0) return {1'b0, 3'd6, 4'd0};
        if (cnt < PATH_LEN) return {1'b0, 3'd4, 4'(cnt)};
        return {1'b1, 3'd0, 4'd15};
    endfunction

    // Monitor: row beats and results are checked whenever the DUT presents them
    always @(negedge clk) begin
        cyc++;
        if (iv_prev && !in_valid) fall_cyc = cyc;
        iv_prev = in_valid;
        if (in_valid) begin
            if (exp_maze_q.size() == 0) check("row_beat_expected", exp_maze_q.size(), 1);
            else check("maze_row", maze, exp_maze_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) check("result_expected", exp_q.size(), 1);
            else begin
                mon_e = exp_q.pop_front();
                mon_l = exp_lat_q.pop_front();
                check("pass", pass, mon_e[7]);
                check("err_code", err_code, mon_e[6:4]);
                check("step_cnt", step_cnt, mon_e[3:0]);
                if (mon_l >= 0) check("timeout_latency", cyc - fall_cyc, mon_l);
            end
        end
    end

    task automatic set_legal_path();
        br.delete();
        bc.delete();
        for (int c = 7; c >= 0; c--) begin br.push_back(0); bc.push_back(c); end
        for (int r = 1; r <= 7; r++) begin br.push_back(r); bc.push_back(0); end
    endtask

    task automatic set_rail_maze();
        load_rows[0] = 8'hFF;
        for (int r = 1; r < 8; r++) load_rows[r] = 8'h01;
    endtask

    task automatic gen_random();
        int r, c, k, n;
        br.delete();
        bc.delete();
        r = 0;
        c = 7;
        br.push_back(r);
        bc.push_back(c);
        for (int i = 1; i < PATH_LEN; i++) begin
            if (r < 7 && (c == 0 || $urandom_range(0, 1) == 1)) r++;
            else c--;
            br.push_back(r);
            bc.push_back(c);
        end
        for (int i = 0; i < 8; i++) load_rows[i] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0)
            for (int i = 0; i < br.size(); i++) load_rows[br[i]][bc[i]] = 1'b1;
        case ($urandom_range(0, 5))
            1: begin
                k = $urandom_range(0, PATH_LEN - 1);
                br[k] = $urandom_range(0, 7);
                bc[k] = $urandom_range(0, 7);
            end
            2: begin
                n = $urandom_range(1, PATH_LEN - 1);
                while (br.size() > n) begin void'(br.pop_back()); void'(bc.pop_back()); end
            end
            3: begin br.push_back(7); bc.push_back(0); end
            default: ;
        endcase
    endtask

    task automatic run_txn(input int mode, input bit do_load, input int delay, input bit poke);
        int         target, t, nb;
        logic [7:0] res;
        target = done_cnt + 1;
        // Rows go in 7..0 so the row-0 write lands in the same cycle as start
        if (do_load) begin
            for (int r = 7; r >= 0; r--) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'(r);
                cfg_data = load_rows[r];
                model_store[r] = load_rows[r];
                if (r > 0) begin @(posedge clk); #1; end
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cfg_we = 1'b0;
        nb = (mode == M_EARLY) ? 4 : 8;
        for (int k = 0; k < nb; k++) exp_maze_q.push_back(model_store[k]);
        if (mode == M_EARLY) begin
            exp_q.push_back({1'b0, 3'd7, 4'd0});
            exp_lat_q.push_back(-1);
        end else if (mode == M_PATH) begin
            res = model_path();
            exp_q.push_back(res);
            exp_lat_q.push_back(res[6:4] == 3'd6 ? TIMEOUT : -1);
        end

        if (mode == M_EARLY) begin
            repeat (3) begin @(posedge clk); #1; end
            out_valid = 1'b1;
            out_row   = 3'd0;
            out_col   = 3'd7;
            @(posedge clk); #1;
            out_valid = 1'b0;
        end else begin
            if (poke) begin
                repeat (2) begin @(posedge clk); #1; end
                cfg_we   = 1'b1;
                cfg_addr = 3'($urandom_range(0, 7));
                cfg_data = ~model_store[cfg_addr];
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
            t = 0;
            while (in_valid && t < 20) begin @(posedge clk); #1; t++; end
            check("in_valid_falls", in_valid, 0);
            if (poke) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            repeat (delay) begin @(posedge clk); #1; end
            for (int i = 0; i < br.size(); i++) begin
                if (mode == M_RESET && i == 3) break;
                out_valid = 1'b1;
                out_row   = 3'(br[i]);
                out_col   = 3'(bc[i]);
                @(posedge clk); #1;
            end
            out_valid = 1'b0;
            if (mode == M_RESET) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check("reset_mid_outputs", int'({maze, in_valid, busy, done, pass, err_code, step_cnt}), 0);
                rst = 1'b0;
                for (int r = 0; r < 8; r++) model_store[r] = 8'h00;
                return;
            end
        end
        t = 0;
        while (done_cnt < target && t < TIMEOUT + 60) begin @(posedge clk); #1; t++; end
        check("done_seen", int'(done_cnt >= target), 1);
        @(posedge clk); #1;
        check("idle_after", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'h00;
        out_valid = 1'b0; out_row = 3'd0; out_col = 3'd0;
        for (int r = 0; r < 8; r++) model_store[r] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'({maze, in_valid, busy, done, pass, err_code, step_cnt}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        set_rail_maze(); set_legal_path();
        run_txn(M_PATH, 1'b1, 0, 1'b0);
        br[0] = 1;
        run_txn(M_PATH, 1'b1, 1, 1'b0);
        set_legal_path();
        br[2] = 1; bc[2] = 6;
        run_txn(M_PATH, 1'b1, 0, 1'b0);
        set_legal_path();
        bc[1] = 5;
        run_txn(M_PATH, 1'b1, 2, 1'b0);
        set_legal_path();
        while (br.size() > 10) begin void'(br.pop_back()); void'(bc.pop_back()); end
        run_txn(M_PATH, 1'b1, 0, 1'b0);
        set_legal_path();
        br.push_back(7); bc.push_back(0);
        run_txn(M_PATH, 1'b1, 0, 1'b0);
        br.delete(); bc.delete();
        run_txn(M_PATH, 1'b1, 0, 1'b0);
        run_txn(M_EARLY, 1'b1, 0, 1'b0);
        set_legal_path();
        run_txn(M_PATH, 1'b1, 1, 1'b1);
        run_txn(M_PATH, 1'b0, 0, 1'b0);
        run_txn(M_RESET, 1'b1, 0, 1'b0);
        run_txn(M_PATH, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int m;
            m = $urandom_range(0, 9);
            gen_random();
            if (m == 1) br.delete();
            if (m == 1) bc.delete();
            run_txn(m == 0 ? M_EARLY : M_PATH, $urandom_range(0, 4) != 0, $urandom_range(0, 5),
                    $urandom_range(0, 5) == 0);
        end

        repeat (4) @(posedge clk);
        check("leftover_results", exp_q.size(), 0);
        check("leftover_rows", exp_maze_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
